// File: rtl/seven_segment_scan.sv
`default_nettype none
// ============================================================================
// seven_segment_scan : multiplexed hex display driver with frame-synchronous
// value update. Option macro SEVEN_SEGMENT_LZ_SUPPRESS_EN blanks leading zeros.
// Revision 1.0
// ============================================================================
module seven_segment_scan #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   blank,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    pending,
   output logic                    frame
);

   localparam int            DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int            IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   logic [DW-1:0]           div;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] display;
   logic [4*NUM_DIGITS-1:0] pend_val;
   logic                    wrap;
   logic                    boundary;
   logic                    suppress;
   logic [3:0]              nibbles [NUM_DIGITS];
   logic [3:0]              digit_nib;
   logic [6:0]              seg_dec;
   logic [6:0]              seg_next;
   logic [NUM_DIGITS-1:0]   an_next;

   assign wrap     = (div == DIV_LAST);
   assign boundary = wrap && (idx == IDX_LAST);

   generate
      for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_nib
         assign nibbles[i] = display[4*i +: 4];
      end
   endgenerate

   assign digit_nib = nibbles[idx];

`ifdef SEVEN_SEGMENT_LZ_SUPPRESS_EN
   // A digit is a leading zero when it and every more significant nibble are zero.
   logic [NUM_DIGITS-1:0] lz_mask;
   generate
      for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
         if (i == 0) begin : g_first
            assign lz_mask[i] = 1'b0;
         end else begin : g_upper
            assign lz_mask[i] = (display[4*NUM_DIGITS-1:4*i] == '0);
         end
      end
   endgenerate
   assign suppress = lz_mask[idx];
`else
   assign suppress = 1'b0;
`endif

   always_comb begin
      seg_dec = 7'b1111111;
      case (digit_nib)
         4'h0: seg_dec = 7'b1000000;
         4'h1: seg_dec = 7'b1111001;
         4'h2: seg_dec = 7'b0100100;
         4'h3: seg_dec = 7'b0110000;
         4'h4: seg_dec = 7'b0011001;
         4'h5: seg_dec = 7'b0010010;
         4'h6: seg_dec = 7'b0000010;
         4'h7: seg_dec = 7'b1111000;
         4'h8: seg_dec = 7'b0000000;
         4'h9: seg_dec = 7'b0010000;
         4'hA: seg_dec = 7'b0001000;
         4'hB: seg_dec = 7'b0000011;
         4'hC: seg_dec = 7'b1000110;
         4'hD: seg_dec = 7'b0100001;
         4'hE: seg_dec = 7'b0000110;
         4'hF: seg_dec = 7'b0001110;
      endcase
      seg_next = (blank[idx] || suppress) ? 7'b1111111 : seg_dec;
      an_next  = ~(NUM_DIGITS'(1) << idx);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         div      <= '0;
         idx      <= '0;
         display  <= '0;
         pend_val <= '0;
         pending  <= 1'b0;
         frame    <= 1'b0;
         seg      <= 7'b1111111;
         an       <= '1;
      end else begin
         frame <= boundary;
         seg   <= seg_next;
         an    <= an_next;
         if (wrap) begin
            div <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            div <= div + 1'b1;
         end
         // Commit uses the pre-edge pending contents, so a load in the boundary
         // cycle lands in pending for the following frame.
         if (boundary && pending) begin
            display <= pend_val;
         end
         if (load) begin
            pend_val <= value;
            pending  <= 1'b1;
         end else if (boundary) begin
            pending <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scan.sv
`default_nettype none
// Bench for seven_segment_scan (NUM_DIGITS=4, SCAN_DIV=4): frame-position
// model feeds an expected-output queue checked one cycle after each edge.
module tb_seven_segment_scan;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] value = '0;
   logic        load = 1'b0;
   logic [3:0]  blank = '0;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        pending;
   logic        frame;

   int errors = 0;
   int checks = 0;
   int k = 0;

   typedef struct packed {
      logic [6:0] seg;
      logic [3:0] an;
      logic       frame;
      logic       pending;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] model_disp = '0;
   logic [15:0] model_pend = '0;
   logic        model_pending = 1'b0;

   seven_segment_scan #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .value  (value),
      .load   (load),
      .blank  (blank),
      .seg    (seg),
      .an     (an),
      .pending(pending),
      .frame  (frame)
   );

   always #5 clock = ~clock;

   // Edges since reset release; edge n lights digit ((n-1)/4)%4.
   always @(posedge clock) begin
      if (!reset_n) k <= 0;
      else          k <= k + 1;
   end

   function automatic logic [6:0] dec(input logic [3:0] n);
      case (n)
         4'h0: dec = 7'b1000000;  4'h1: dec = 7'b1111001;
         4'h2: dec = 7'b0100100;  4'h3: dec = 7'b0110000;
         4'h4: dec = 7'b0011001;  4'h5: dec = 7'b0010010;
         4'h6: dec = 7'b0000010;  4'h7: dec = 7'b1111000;
         4'h8: dec = 7'b0000000;  4'h9: dec = 7'b0010000;
         4'hA: dec = 7'b0001000;  4'hB: dec = 7'b0000011;
         4'hC: dec = 7'b1000110;  4'hD: dec = 7'b0100001;
         4'hE: dec = 7'b0000110;  default: dec = 7'b0001110;
      endcase
   endfunction

   function automatic logic [6:0] model_seg(input logic [15:0] disp, input int d,
                                            input logic [3:0] blk);
      logic [15:0] sh;
      sh = disp >> (4 * d);
      model_seg = dec(sh[3:0]);
      if (blk[d]) model_seg = 7'b1111111;
`ifdef SEVEN_SEGMENT_LZ_SUPPRESS_EN
      if (d > 0 && sh == 16'h0000) model_seg = 7'b1111111;
`endif
   endfunction

   // Drives one cycle of stimulus and queues what the DUT must show after the edge.
   task automatic drive_cycle(input logic ld, input logic [15:0] val, input logic [3:0] blk);
      exp_t e;
      int   en;
      int   d;
      en = k + 1;
      d = ((en - 1) / 4) % 4;
      e.an = ~(4'b0001 << d);
      e.seg = model_seg(model_disp, d, blk);
      e.frame = (en % 16 == 0);
      if (e.frame && model_pending) begin
         model_disp = model_pend;
         model_pending = 1'b0;
      end
      if (ld) begin
         model_pend = val;
         model_pending = 1'b1;
      end
      e.pending = model_pending;
      exp_q.push_back(e);
      load = ld;
      value = val;
      blank = blk;
      @(posedge clock);
      #1;
      load = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
      checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got=%b exp=1111", an); end
      checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b exp=0", pending); end
      checks++; if (frame !== 1'b0) begin errors++; $display("FAIL reset_frame got=%b exp=0", frame); end
      reset_n = 1'b1;
      drive_cycle(1'b0, 16'h0, 4'h0);
      void'(exp_q.pop_front());
      checks++; if ({an, seg} !== {4'b1110, 7'b1000000}) begin
         errors++; $display("FAIL first_edge got an=%b seg=%b exp an=1110 seg=1000000", an, seg);
      end
   endtask

   task automatic test_idle;
      exp_t g;
      int   pulses = 0;
      for (int c = 0; c < 15; c++) begin
         drive_cycle(1'b0, 16'h0, 4'h0);
         g = exp_q.pop_front();
         if (frame === 1'b1) pulses++;
         checks++; if ({seg, an, frame, pending} !== g) begin
            errors++; $display("FAIL idle k=%0d got seg=%b an=%b fr=%b pd=%b exp %b", k, seg, an, frame, pending, g);
         end
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL idle_frame_pulses got=%0d exp=1", pulses); end
   endtask

   task automatic test_load;
      exp_t       g;
      logic [6:0] want [4];
      want[0] = 7'b0001110; want[1] = 7'b0001000; want[2] = 7'b0100100; want[3] = 7'b1111001;
      for (int c = 0; c < 32; c++) begin
         drive_cycle(k + 1 == 21, 16'h12AF, 4'h0);
         g = exp_q.pop_front();
         checks++; if ({seg, an, frame, pending} !== g) begin
            errors++; $display("FAIL load k=%0d got seg=%b an=%b fr=%b pd=%b exp %b", k, seg, an, frame, pending, g);
         end
         if (k > 32) begin
            checks++; if (seg !== want[((k - 1) / 4) % 4]) begin
               errors++; $display("FAIL load_digit k=%0d got=%b exp=%b", k, seg, want[((k - 1) / 4) % 4]);
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      exp_t g;
      for (int c = 0; c < 32; c++) begin
         if ((k + 1) % 16 == 3)      drive_cycle(1'b1, 16'h1111, 4'h0);
         else if ((k + 1) % 16 == 7) drive_cycle(1'b1, 16'h2222, 4'h0);
         else                        drive_cycle(1'b0, 16'h0, 4'h0);
         g = exp_q.pop_front();
         checks++; if ({seg, an, frame, pending} !== g) begin
            errors++; $display("FAIL b2b k=%0d got seg=%b an=%b fr=%b pd=%b exp %b", k, seg, an, frame, pending, g);
         end
      end
   endtask

   task automatic test_load_at_boundary;
      exp_t g;
      for (int c = 0; c < 48; c++) begin
         if (k + 1 == 85)       drive_cycle(1'b1, 16'h1111, 4'h0);
         else if (k + 1 == 96)  drive_cycle(1'b1, 16'h3333, 4'h0);
         else                   drive_cycle(1'b0, 16'h0, 4'h0);
         g = exp_q.pop_front();
         checks++; if ({seg, an, frame, pending} !== g) begin
            errors++; $display("FAIL boundary_load k=%0d got seg=%b an=%b fr=%b pd=%b exp %b", k, seg, an, frame, pending, g);
         end
         if (k == 97 || k == 113) begin
            checks++; if (seg !== ((k == 97) ? 7'b1111001 : 7'b0110000)) begin
               errors++; $display("FAIL boundary_digit0 k=%0d got=%b", k, seg);
            end
         end
      end
   endtask

   task automatic test_blank;
      exp_t       g;
      logic [6:0] want [4];
      want[0] = 7'b0100100; want[1] = 7'b0011001; want[2] = 7'b1111111;
`ifdef SEVEN_SEGMENT_LZ_SUPPRESS_EN
      want[3] = 7'b1111111;
`else
      want[3] = 7'b1000000;
`endif
      for (int c = 0; c < 32; c++) begin
         drive_cycle(k + 1 == 130, 16'h0042, (k >= 144) ? 4'b0100 : 4'b0000);
         g = exp_q.pop_front();
         checks++; if ({seg, an, frame, pending} !== g) begin
            errors++; $display("FAIL blank k=%0d got seg=%b an=%b fr=%b pd=%b exp %b", k, seg, an, frame, pending, g);
         end
         if (k > 144) begin
            checks++; if (seg !== want[((k - 1) / 4) % 4]) begin
               errors++; $display("FAIL blank_digit k=%0d got=%b exp=%b", k, seg, want[((k - 1) / 4) % 4]);
            end
         end
      end
   endtask

   task automatic test_reset_pending;
      exp_t g;
      for (int c = 0; c < 6; c++) begin
         drive_cycle(k + 1 == 165, 16'h5555, 4'h0);
         g = exp_q.pop_front();
         checks++; if ({seg, an, frame, pending} !== g) begin
            errors++; $display("FAIL pre_reset k=%0d got seg=%b an=%b fr=%b pd=%b exp %b", k, seg, an, frame, pending, g);
         end
      end
      reset_n = 1'b0;
      model_disp = '0;
      model_pend = '0;
      model_pending = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      checks++; if ({seg, an, frame, pending} !== {7'b1111111, 4'b1111, 1'b0, 1'b0}) begin
         errors++; $display("FAIL midreset got seg=%b an=%b fr=%b pd=%b exp 1111111 1111 0 0", seg, an, frame, pending);
      end
      for (int c = 0; c < 32; c++) begin
         drive_cycle(1'b0, 16'h0, 4'h0);
         g = exp_q.pop_front();
         checks++; if ({seg, an, frame, pending} !== g) begin
            errors++; $display("FAIL post_reset k=%0d got seg=%b an=%b fr=%b pd=%b exp %b", k, seg, an, frame, pending, g);
         end
      end
   endtask

   initial begin
      test_reset;
      test_idle;
      test_load;
      test_back_to_back;
      test_load_at_boundary;
      test_blank;
      test_reset_pending;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
